// File: rtl/borrow_skip_subtractor_if.sv
// Operand/result handshake bundle for borrow_skip_subtractor.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
interface borrow_skip_subtractor_if #(
  parameter int WIDTH = 16
);
  localparam int N  = WIDTH / 4;
  localparam int SW = $clog2(N) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic [SW-1:0]    skip_count;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, skip_count
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, skip_count
  );
endinterface

// File: rtl/borrow_skip_subtractor.sv
// Multi-cycle a - b - bin, one 4-bit block per clock, computed as a + ~b + ~bin
// with a carry-skip path around blocks whose bits all propagate.
module borrow_skip_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  borrow_skip_subtractor_if.slave    bus,
  output logic [1:0]                 dbg_state_o
);
  localparam int N  = WIDTH / 4;
  localparam int SW = $clog2(N) + 1;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             c_q, c_d;
  logic             bout_q, bout_d;
  logic [SW-1:0]    skip_q, skip_d;

  // Current block datapath
  logic [KW+1:0] base;
  logic [3:0]    blk_a, blk_nb, blk_p, blk_s;
  logic          rip;
  logic          c_next;

  always_comb begin
    base   = {k_q, 2'b00};
    blk_a  = a_q[base +: 4];
    blk_nb = ~b_q[base +: 4];
    blk_p  = blk_a ^ blk_nb;
    rip    = c_q;
    blk_s  = '0;
    for (int i = 0; i < 4; i++) begin
      blk_s[i] = blk_p[i] ^ rip;
      rip      = (blk_a[i] & blk_nb[i]) | (blk_a[i] & rip) | (blk_nb[i] & rip);
    end
    // When every bit propagates the ripple carry equals c_q, so skipping is exact.
    c_next = (&blk_p) ? c_q : rip;
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    c_d     = c_q;
    bout_d  = bout_q;
    skip_d  = skip_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          c_d     = ~bus.bin;
          k_d     = '0;
          skip_d  = '0;
          diff_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d[base +: 4] = blk_s;
        c_d = c_next;
        if (&blk_p) skip_d = skip_q + SW'(1);
        if (k_q == LAST_K) begin
          bout_d  = ~c_next;
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      c_q     <= 1'b0;
      bout_q  <= 1'b0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      c_q     <= c_d;
      bout_q  <= bout_d;
      skip_q  <= skip_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.bout       = bout_q;
  assign bus.skip_count = skip_q;
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_borrow_skip_subtractor.sv
// Self-checking bench for borrow_skip_subtractor (WIDTH=16): directed vectors,
// backpressure, async reset mid-operation, and a randomized back-to-back stream.
module tb_borrow_skip_subtractor;
  localparam int W  = 16;
  localparam int RW = 20;  // {skip_count[2:0], bout, diff[15:0]}

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         checks;
  int         errors;
  int         cyc;
  logic [RW-1:0] exp_q[$];

  borrow_skip_subtractor_if #(.WIDTH(W)) bus ();

  borrow_skip_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer subtraction; a block skips when its a and b nibbles are equal.
  function automatic logic [RW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int d;
    int cnt;
    logic [W-1:0] df;
    logic bo;
    d   = int'(a) - int'(b) - int'(bin);
    df  = W'(d);
    bo  = (d < 0);
    cnt = 0;
    for (int i = 0; i < W / 4; i++)
      if (a[4*i +: 4] == b[4*i +: 4]) cnt++;
    return {3'(cnt), bo, df};
  endfunction

  function automatic logic [RW-1:0] observed();
    return {bus.skip_count, bus.bout, bus.diff};
  endfunction

  // Driver tasks: all run at #1 after a rising edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    check_eq("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_eq({tag, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
    check_eq({tag, "_out_valid_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input logic [RW-1:0] exp);
    start_op(a, b, bin);
    wait_done(tag, 4);
    check_eq({tag, "_result"}, 32'(observed()), 32'(exp));
    release_result(tag);
  endtask

  initial begin
    int accepted;
    int last_acc;
    logic [W-1:0] ra, rb;
    logic rbin;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("reset_outputs", 32'(observed()), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    directed("sub_1234_0034", 16'h1234, 16'h0034, 1'b0, {3'd2, 1'b0, 16'h1200});
    directed("sub_0000_0001", 16'h0000, 16'h0001, 1'b0, {3'd3, 1'b1, 16'hFFFF});
    directed("sub_ffff_ffff_b1", 16'hFFFF, 16'hFFFF, 1'b1, {3'd4, 1'b1, 16'hFFFF});
    directed("sub_8000_7fff", 16'h8000, 16'h7FFF, 1'b0, {3'd0, 1'b0, 16'h0001});

    // Backpressure: DONE held while inputs wiggle
    start_op(16'h1234, 16'h0034, 1'b0);
    wait_done("bp", 4);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = (i != 1);
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      bus.bin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_eq("bp_result_stable", 32'(observed()), 32'({3'd2, 1'b0, 16'h1200}));
      check_eq("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      check_eq("bp_out_valid_high", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    release_result("bp");
    @(posedge clk); #1;
    check_eq("bp_not_accepted", 32'(bus.in_ready), 32'd1);

    // Async reset two cycles into RUN
    start_op(16'h1234, 16'h0034, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_eq("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("arst_diff", 32'(bus.diff), 32'd0);
    check_eq("arst_skip", 32'(bus.skip_count), 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("arst_no_out_valid", 32'(bus.out_valid), 32'd0);
    directed("post_reset_5_3", 16'h0005, 16'h0003, 1'b0, {3'd3, 1'b0, 16'h0002});

    // Randomized back-to-back stream
    accepted = 0;
    last_acc = -1;
    exp_q.delete();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 400 && (accepted < 20 || exp_q.size() > 0); t++) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) check_eq("stream_stray_result", 32'd1, 32'd0);
        else check_eq("stream_result", 32'(observed()), 32'(exp_q.pop_front()));
      end
      if (bus.in_ready && accepted < 20) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        for (int k = 0; k < 4; k++)
          if ($urandom_range(0, 1) == 1) rb[4*k +: 4] = ra[4*k +: 4];
        rbin = 1'($urandom_range(0, 1));
        bus.a = ra;
        bus.b = rb;
        bus.bin = rbin;
        exp_q.push_back(model(ra, rb, rbin));
        if (last_acc >= 0) check_eq("stream_spacing", 32'(cyc - last_acc), 32'd6);
        last_acc = cyc;
        accepted++;
      end else if (accepted >= 20) begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check_eq("stream_accepted", 32'(accepted), 32'd20);
    check_eq("stream_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
